// File: rtl/dsp_pkg.sv
// Shared definitions for the sequential DSP blocks: FSM state codes and Q1.15 limits.
package dsp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

endpackage

// File: rtl/seq_mult_q15_if.sv
// Start/done handshake and result bus of the sequential Q1.(N-1) multiplier.
interface seq_mult_q15_if #(parameter int N = 16);

    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic [N-1:0]   y;
    logic           ovf;

    modport master (output start, a, b, input busy, done, product, y, ovf);
    modport slave  (input start, a, b, output busy, done, product, y, ovf);

endinterface

// File: rtl/q_round_sat.sv
// Maps a signed Q2.(2N-2) product onto a rounded (or floored), saturated Q1.(N-1) value.
module q_round_sat #(
    parameter int N     = 16,
    parameter bit ROUND = 1'b1
) (
    input  logic signed [2*N-1:0] product_i,
    output logic        [N-1:0]   y_o,
    output logic                  ovf_o
);

    localparam logic signed [2*N:0] BIAS  = ROUND ? ((2*N+1)'(1) << (N-2)) : '0;
    localparam logic signed [2*N:0] Y_MAX = (2*N+1)'((1 << (N-1)) - 1);

    logic signed [2*N:0] sum;
    logic signed [2*N:0] shifted;

    // One guard bit keeps the bias add from wrapping at the positive extreme.
    assign sum     = $signed({product_i[2*N-1], product_i}) + BIAS;
    assign shifted = sum >>> (N-1);

    always_comb begin
        y_o   = shifted[N-1:0];
        ovf_o = 1'b0;
        if (shifted > Y_MAX) begin
            y_o   = Y_MAX[N-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/seq_mult_q15.sv
// Shift-add signed fractional multiplier: N magnitude iterations, sign applied on entry to DONE.
module seq_mult_q15
    import dsp_pkg::*;
#(
    parameter int N     = 16,
    parameter bit ROUND = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    seq_mult_q15_if.slave bus
);

    localparam int CW = $clog2(N);

    logic [1:0]     state_q,   state_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic [2*N-1:0] mcand_q,   mcand_d;
    logic [N-1:0]   mult_q,    mult_d;
    logic [2*N-1:0] acc_q,     acc_d;
    logic           sign_q,    sign_d;
    logic           done_q,    done_d;
    logic [2*N-1:0] product_q, product_d;
    logic [N-1:0]   y_q,       y_d;
    logic           ovf_q,     ovf_d;

    logic [N-1:0]   a_abs;
    logic [N-1:0]   b_abs;
    logic [2*N-1:0] acc_step;
    logic [N-1:0]   y_sat;
    logic           ovf_sat;

    // The magnitude of the most-negative operand is still representable as N-bit unsigned.
    assign a_abs    = bus.a[N-1] ? (~bus.a + 1'b1) : bus.a;
    assign b_abs    = bus.b[N-1] ? (~bus.b + 1'b1) : bus.b;
    assign acc_step = acc_q + (mult_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        done_d    = 1'b0;
        product_d = product_q;
        y_d       = y_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_RUN: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    product_d = sign_q ? (~acc_step + 1'b1) : acc_step;
                    y_d       = y_sat;
                    ovf_d     = ovf_sat;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    state_d = ST_RUN;
                    mcand_d = {{N{1'b0}}, a_abs};
                    mult_d  = b_abs;
                    sign_d  = bus.a[N-1] ^ bus.b[N-1];
                    acc_d   = '0;
                    cnt_d   = CW'(N-1);
                end
            end
        endcase
    end

    q_round_sat #(.N(N), .ROUND(ROUND)) u_round_sat (
        .product_i (product_d),
        .y_o       (y_sat),
        .ovf_o     (ovf_sat)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
            sign_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            y_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            done_q    <= done_d;
            product_q <= product_d;
            y_q       <= y_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.y       = y_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_seq_mult_q15.sv
// Directed checks of the sequential Q1.15 multiplier plus a short model-checked random sweep.
module tb_seq_mult_q15;
    import dsp_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_mult_q15_if #(.N(N)) bus ();

    seq_mult_q15 #(.N(N), .ROUND(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Issues one operation and returns the number of edges after the accepting edge until done.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, output int lat,
                         output logic [31:0] p, output logic [15:0] yv, output logic ov);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 3*N) begin
            @(posedge clk); #1;
            lat++;
        end
        p  = bus.product;
        yv = bus.y;
        ov = bus.ovf;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.product !== 32'h0) begin n_bad++; $display("FAIL reset_product got=%h exp=0", bus.product); end
        n_cmp++; if (bus.y !== 16'h0)       begin n_bad++; $display("FAIL reset_y got=%h exp=0", bus.y); end
        n_cmp++; if (bus.ovf !== 1'b0)      begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: busy=%b done=%b product=%h y=%h ovf=%b", bus.busy, bus.done, bus.product, bus.y, bus.ovf);
    endtask

    task automatic test_directed();
        logic [15:0] va [6] = '{16'h4000, 16'hC000, Q15_MIN, Q15_MAX, 16'h0003, 16'hC000};
        logic [15:0] vb [6] = '{16'h4000, 16'h4000, Q15_MIN, Q15_MAX, 16'hFFFF, 16'hC000};
        logic [31:0] ep [6] = '{32'h10000000, 32'hF0000000, 32'h40000000, 32'h3FFF0001, 32'hFFFFFFFD, 32'h10000000};
        logic [15:0] ey [6] = '{16'h2000, 16'hE000, 16'h7FFF, 16'h7FFE, 16'h0000, 16'h2000};
        logic        eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int          lat;
        logic [31:0] p;
        logic [15:0] yv;
        logic        ov;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], lat, p, yv, ov);
            $display("op a=%h b=%h -> product=%h y=%h ovf=%b lat=%0d", va[i], vb[i], p, yv, ov, lat);
            n_cmp++; if (lat !== N)    begin n_bad++; $display("FAIL latency[%0d] got=%0d exp=%0d", i, lat, N); end
            n_cmp++; if (p !== ep[i])  begin n_bad++; $display("FAIL product[%0d] got=%h exp=%h", i, p, ep[i]); end
            n_cmp++; if (yv !== ey[i]) begin n_bad++; $display("FAIL y[%0d] got=%h exp=%h", i, yv, ey[i]); end
            n_cmp++; if (ov !== eo[i]) begin n_bad++; $display("FAIL ovf[%0d] got=%b exp=%b", i, ov, eo[i]); end
            @(posedge clk); #1;
            n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse[%0d] got=%b exp=0", i, bus.done); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3] = '{16'h4000, 16'hC000, 16'h7FFF};
        logic [15:0] vb [3] = '{16'h4000, 16'h4000, 16'h7FFF};
        logic [31:0] ep [3] = '{32'h10000000, 32'hF0000000, 32'h3FFF0001};
        int          lat;
        bus.a     = va[0];
        bus.b     = vb[0];
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                bus.a = va[k+1];
                bus.b = vb[k+1];
            end else begin
                bus.start = 1'b0;
            end
            lat = 0;
            while (bus.done !== 1'b1 && lat < 3*N) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("b2b op%0d: product=%h lat=%0d", k, bus.product, lat);
            n_cmp++; if (lat !== N)             begin n_bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", k, lat, N); end
            n_cmp++; if (bus.product !== ep[k]) begin n_bad++; $display("FAIL b2b_product[%0d] got=%h exp=%h", k, bus.product, ep[k]); end
            @(posedge clk); #1;
            n_cmp++; if (bus.done !== 1'b0)     begin n_bad++; $display("FAIL b2b_done_pulse[%0d] got=%b exp=0", k, bus.done); end
            n_cmp++; if (bus.busy !== (k < 2))  begin n_bad++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", k, bus.busy, (k < 2)); end
        end
    endtask

    task automatic test_busy_start();
        int extra_done = 0;
        int lat;
        bus.a     = 16'h4000;
        bus.b     = 16'h4000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.a     = 16'h7FFF;
        bus.b     = 16'h8000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 4;
        while (bus.done !== 1'b1 && lat < 3*N) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("busy-start: product=%h y=%h lat=%0d", bus.product, bus.y, lat);
        n_cmp++; if (lat !== N)                  begin n_bad++; $display("FAIL busy_latency got=%0d exp=%0d", lat, N); end
        n_cmp++; if (bus.product !== 32'h10000000) begin n_bad++; $display("FAIL busy_product got=%h exp=10000000", bus.product); end
        n_cmp++; if (bus.y !== 16'h2000)         begin n_bad++; $display("FAIL busy_y got=%h exp=2000", bus.y); end
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
        end
        n_cmp++; if (extra_done !== 0) begin n_bad++; $display("FAIL busy_requeued got=%0d exp=0", extra_done); end
    endtask

    task automatic test_reset_mid_run();
        int          seen_done = 0;
        int          lat;
        logic [31:0] p;
        logic [15:0] yv;
        logic        ov;
        bus.a     = 16'h7FFF;
        bus.b     = 16'h7FFF;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid-run: busy=%b done=%b product=%h y=%h", bus.busy, bus.done, bus.product, bus.y);
        n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.product !== 32'h0) begin n_bad++; $display("FAIL midrst_product got=%h exp=0", bus.product); end
        n_cmp++; if (bus.y !== 16'h0)       begin n_bad++; $display("FAIL midrst_y got=%h exp=0", bus.y); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done++;
        end
        n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL midrst_done got=%0d exp=0", seen_done); end
        do_op(16'hC000, 16'hC000, lat, p, yv, ov);
        $display("after reset: product=%h y=%h lat=%0d", p, yv, lat);
        n_cmp++; if (p !== 32'h10000000) begin n_bad++; $display("FAIL postrst_product got=%h exp=10000000", p); end
        n_cmp++; if (yv !== 16'h2000)    begin n_bad++; $display("FAIL postrst_y got=%h exp=2000", yv); end
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] p;
        logic [15:0] yv;
        logic        ov;
        logic [15:0] av;
        logic [15:0] bv;
        longint      ep;
        longint      t;
        logic [15:0] ey;
        logic        eo;
        for (int i = 0; i < 200; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            ep = longint'($signed(av)) * longint'($signed(bv));
            t  = (ep + 64'sd16384) >>> 15;
            eo = (t > 64'sd32767);
            ey = eo ? Q15_MAX : 16'(t);
            do_op(av, bv, lat, p, yv, ov);
            $display("rnd a=%h b=%h -> product=%h y=%h ovf=%b", av, bv, p, yv, ov);
            n_cmp++; if (p !== 32'(ep)) begin n_bad++; $display("FAIL rnd_product a=%h b=%h got=%h exp=%h", av, bv, p, 32'(ep)); end
            n_cmp++; if (yv !== ey || ov !== eo) begin
                n_bad++; $display("FAIL rnd_y a=%h b=%h got=%h/%b exp=%h/%b", av, bv, yv, ov, ey, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_start();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
